// File: rtl/param_register_file.sv
// param_register_file: multi-port register file with bypass, busy scoreboard and scrub sequencer
module param_register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                         Clock,
    input  logic                         R,
    input  logic                         WriteEn0,
    input  logic [ADDR_W-1:0]            WriteReg0,
    input  logic [WIDTH-1:0]             WriteData0,
    input  logic                         WriteEn1,
    input  logic [ADDR_W-1:0]            WriteReg1,
    input  logic [WIDTH-1:0]             WriteData1,
    input  logic [NUM_READ*ADDR_W-1:0]   ReadReg,
    output logic [NUM_READ*WIDTH-1:0]    ReadData,
    output logic [NUM_READ-1:0]          ReadBusy,
    input  logic                         IssueEn,
    input  logic [ADDR_W-1:0]            IssueReg,
    input  logic                         Clear,
    output logic                         ClearBusy
);
    typedef enum logic {IDLE, SCRUB} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              w_idle;
    logic              w_we0;
    logic              w_we1;
    logic              w_iss;
    logic              w_last;

    // Qualified enables: scrub blocks all updates, and the zero register never takes writes or issues
    always_comb begin
        w_idle = (r_state == IDLE);
        w_we0  = w_idle && WriteEn0 && !(ZERO_REG != 0 && WriteReg0 == '0);
        w_we1  = w_idle && WriteEn1 && !(ZERO_REG != 0 && WriteReg1 == '0);
        w_iss  = w_idle && IssueEn && !(ZERO_REG != 0 && IssueReg == '0);
        w_last = (r_idx == ADDR_W'(DEPTH - 1));
        w_state_nxt = w_idle ? (Clear ? SCRUB : IDLE) : (w_last ? IDLE : SCRUB);
        ClearBusy = (r_state == SCRUB);
    end

    // Scrub sequencer: index restarts on entry and advances once per scrub cycle
    always_ff @(posedge Clock) begin
        if (R) begin
            r_state <= IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idle ? '0 : r_idx + 1'b1;
        end
    end

    // Storage and scoreboard; port 1 is written last so it wins a collision, issue set beats write clear
    always_ff @(posedge Clock) begin
        if (R) begin
            for (int i = 0; i < DEPTH; i++) r_mem[ADDR_W'(i)] <= '0;
            r_busy <= '0;
        end else if (!w_idle) begin
            r_mem[r_idx]  <= '0;
            r_busy[r_idx] <= 1'b0;
        end else begin
            if (w_we0) r_mem[WriteReg0] <= WriteData0;
            if (w_we1) r_mem[WriteReg1] <= WriteData1;
            if (w_we0) r_busy[WriteReg0] <= 1'b0;
            if (w_we1) r_busy[WriteReg1] <= 1'b0;
            if (w_iss) r_busy[IssueReg] <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_hit0;
        logic              w_hit1;
        assign w_addr = ReadReg[k*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        assign w_hit1 = (BYPASS != 0) && w_we1 && (WriteReg1 == w_addr);
        assign w_hit0 = (BYPASS != 0) && w_we0 && (WriteReg0 == w_addr);
        assign ReadData[k*WIDTH +: WIDTH] = w_zero ? '0 : w_hit1 ? WriteData1 : w_hit0 ? WriteData0 : r_mem[w_addr];
        assign ReadBusy[k] = !w_zero && !w_hit0 && !w_hit1 && r_busy[w_addr];
    end
endmodule

// File: doc/param_register_file.md
Name: param_register_file

Overview:
- Parametrised successor to the fixed 32x32, 2-read/1-write register file in the Memory library.
- Generalises width, depth and read-port count; adds a second write port, optional write-through bypass, a per-register pending-write scoreboard and a multi-cycle scrub (clear-all) sequencer.
- Sits between decode (read and issue) and writeback (two write ports) in the pipelined core.

Parameters:
- WIDTH, 32, bits per register.
- DEPTH, 32, number of registers; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), register address width.
- NUM_READ, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1, entry 0 is hardwired zero.
- BYPASS, 1, when 1, reads see same-cycle write data.

Ports:
- Clock  in  1  sole clock; all state updates on rising edge.
- R  in  1  reset; synchronous, active-high.
- WriteEn0  in  1  write port 0 enable.
- WriteReg0  in  ADDR_W  write port 0 address.
- WriteData0  in  WIDTH  write port 0 data.
- WriteEn1  in  1  write port 1 enable.
- WriteReg1  in  ADDR_W  write port 1 address.
- WriteData1  in  WIDTH  write port 1 data.
- ReadReg  in  NUM_READ*ADDR_W  read addresses; port k is slice [k*ADDR_W +: ADDR_W].
- ReadData  out  NUM_READ*WIDTH  read data; port k is slice [k*WIDTH +: WIDTH].
- ReadBusy  out  NUM_READ  scoreboard bit for each read port's addressed register.
- IssueEn  in  1  marks IssueReg pending (busy).
- IssueReg  in  ADDR_W  register being issued.
- Clear  in  1  one-cycle pulse that starts a scrub.
- ClearBusy  out  1  high while a scrub is in progress.

Behaviour:
- Reset (R=1 at a rising edge):
  - all entries, all busy bits and the scrub index go to 0; FSM goes to IDLE; ClearBusy=0.
  - R overrides every other input in that cycle, including a scrub in progress.
- Reads: combinational, zero latency. ReadData[k] = entry[ReadReg[k]], subject to the zero-register and bypass rules below.
- Writes: take effect at the rising edge; visible to non-bypassed reads the following cycle.
- Write collision (WriteEn0 and WriteEn1, same address): port 1 wins; port 0 data is discarded.
- ZERO_REG=1:
  - writes and issues to address 0 are ignored.
  - read of address 0 returns 0; ReadBusy for address 0 is always 0.
- BYPASS=1:
  - if a read address matches an enabled, non-ignored write this cycle, ReadData returns that write data; port 1 has priority over port 0.
  - the hit also forces ReadBusy for that port to 0.
- BYPASS=0: reads return the pre-edge stored value.
- Scoreboard (DEPTH bits):
  - IssueEn sets busy[IssueReg] at the edge.
  - a write on either port clears busy[WriteReg] at the edge.
  - issue and write to the same register in one cycle: busy ends set (issue wins).
  - ReadBusy[k] is combinational from the current busy bits, after the zero-register and bypass overrides.
- Scrub FSM, states IDLE and SCRUB:
  - IDLE -> SCRUB on Clear=1: index <= 0, ClearBusy <= 1.
  - each SCRUB cycle: entry[index] <= 0, busy[index] <= 0, index <= index+1.
  - after writing index DEPTH-1: go to IDLE, ClearBusy <= 0. Total DEPTH cycles, ClearBusy high for exactly DEPTH cycles.
  - in SCRUB, WriteEn0, WriteEn1, IssueEn and Clear are ignored.
  - reads stay live in SCRUB and return current contents; bypass is disabled in SCRUB.
- Index arithmetic is ADDR_W bits wide; wrap from DEPTH-1 is the terminal condition, not a restart.

Test Plan:
- Reset then read: R=1 for 1 cycle, ReadReg={5,3} -> ReadData=0, ReadBusy=0, ClearBusy=0.
- Dual-write collision: WriteEn0=WriteEn1=1, both to reg 7, data 0xAAAA0000 / 0x12345678 -> next-cycle read of reg 7 = 0x12345678.
- Bypass: BYPASS=1, write reg 9 = 0xDEADBEEF while ReadReg[0]=9 -> same-cycle ReadData[0]=0xDEADBEEF. Rebuild with BYPASS=0 -> same-cycle returns old value 0, next cycle 0xDEADBEEF.
- Zero register: write 0xFFFFFFFF to reg 0 and IssueEn with IssueReg=0 -> read of reg 0 = 0, ReadBusy=0.
- Scoreboard: issue reg 4 -> ReadBusy=1 next cycle. Same-cycle issue+write to reg 4 -> still 1. Write-only to reg 4 -> 0.
- Scrub: fill regs 1..31 with nonzero values and set busy on reg 10, pulse Clear -> ClearBusy high exactly 32 cycles; WriteEn0 to reg 2 during scrub has no effect; afterwards all reads are 0 with no busy bits. Assert R at scrub cycle 5 -> next cycle IDLE, all entries 0.
